// File: rtl/wb_write_arbiter_if.sv
// Bus bundle between the ALU/load write sources, decode and the writeback port.
// Signals: alu_* write, ld_* handshake, q_src_* hazard query, register file write.
interface wb_write_arbiter_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic [AW-1:0] alu_dest;
  logic [DW-1:0] alu_data;

  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_dest;
  logic [DW-1:0] ld_data;

  logic [AW-1:0] q_src_1;
  logic [AW-1:0] q_src_2;
  logic          hazard;
  logic [CW-1:0] fifo_count;

  logic          WB_WB_EN;
  logic [AW-1:0] Dest_wb;
  logic [DW-1:0] dest_wb;

  modport master (
    output alu_valid, alu_dest, alu_data,
    output ld_valid, ld_dest, ld_data,
    output q_src_1, q_src_2,
    input  ld_ready, hazard, fifo_count,
    input  WB_WB_EN, Dest_wb, dest_wb
  );

  modport slave (
    input  alu_valid, alu_dest, alu_data,
    input  ld_valid, ld_dest, ld_data,
    input  q_src_1, q_src_2,
    output ld_ready, hazard, fifo_count,
    output WB_WB_EN, Dest_wb, dest_wb
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Writeback arbiter: merges ALU writes and buffered load writes onto the
// single register file write port, one write per cycle, registered.
// Ports: clk, rst (sync, active high), bus (slave modport):
//   alu_valid/alu_dest/alu_data   ALU write, always accepted
//   ld_valid/ld_ready/ld_dest/ld_data  load write handshake into FIFO
//   q_src_1/q_src_2 -> hazard     live FIFO entry targets a source
//   fifo_count                    occupied FIFO slots (killed included)
//   WB_WB_EN/Dest_wb/dest_wb      registered register file write
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 4,
  parameter int DW    = 32
) (
  input logic              clk,
  input logic              rst,
  wb_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  // Register 15 has no storage; writes to it vanish.
  localparam logic [AW-1:0] NOREG = AW'(15);

  logic [AW-1:0] r_dest [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [DEPTH-1:0] r_live;
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;

  logic          r_en;
  logic [AW-1:0] r_wdest;
  logic [DW-1:0] r_wdata;

  logic             w_ready;
  logic             w_push;
  logic             w_alu;
  logic             w_pop;
  logic             w_head_live;
  logic             w_haz;
  logic [DEPTH-1:0] w_live_nxt;

  assign w_ready = !rst && (r_count < CW'(DEPTH));
  assign w_push  = bus.ld_valid && w_ready
                && (bus.ld_dest != NOREG);
  assign w_alu   = bus.alu_valid
                && (bus.alu_dest != NOREG);
  assign w_pop   = !w_alu && (r_count != '0);
  assign w_head_live = r_live[r_rd];

  // A slot's live bit is cleared on pop, so a set
  // bit always means an occupied, unsuperseded entry.
  always_comb begin
    w_haz = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_live[i] &&
          ((r_dest[i] == bus.q_src_1) ||
           (r_dest[i] == bus.q_src_2)))
        w_haz = 1'b1;
    end
  end

  // Kill older entries superseded by this cycle's
  // ALU write; a load pushed now is newer and the
  // push assignment overrides the kill.
  always_comb begin
    w_live_nxt = r_live;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_alu && r_live[i] &&
          (r_dest[i] == bus.alu_dest))
        w_live_nxt[i] = 1'b0;
    end
    if (w_pop)
      w_live_nxt[r_rd] = 1'b0;
    if (w_push)
      w_live_nxt[r_wr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_live  <= '0;
      r_en    <= 1'b0;
      r_wdest <= '0;
      r_wdata <= '0;
    end else begin
      r_live  <= w_live_nxt;
      r_count <= r_count
               + CW'(w_push)
               - CW'(w_pop);
      if (w_push) begin
        r_dest[r_wr] <= bus.ld_dest;
        r_data[r_wr] <= bus.ld_data;
        r_wr <= r_wr + PW'(1);
      end
      if (w_pop)
        r_rd <= r_rd + PW'(1);
      unique case (1'b1)
        w_alu: begin
          r_en    <= 1'b1;
          r_wdest <= bus.alu_dest;
          r_wdata <= bus.alu_data;
        end
        w_pop: begin
          // A killed head still drains its slot
          // but produces no write.
          r_en <= w_head_live;
          if (w_head_live) begin
            r_wdest <= r_dest[r_rd];
            r_wdata <= r_data[r_rd];
          end
        end
        default: r_en <= 1'b0;
      endcase
    end
  end

  assign bus.ld_ready   = w_ready;
  assign bus.hazard     = w_haz;
  assign bus.fifo_count = r_count;
  assign bus.WB_WB_EN   = r_en;
  assign bus.Dest_wb    = r_wdest;
  assign bus.dest_wb    = r_wdata;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Self-checking bench for wb_write_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_wb_write_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = 4;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wb_write_arbiter_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  wb_write_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [AW-1:0] dest;
    logic [DW-1:0] data;
    bit            live;
  } ent_t;

  ent_t          mq[$];
  logic          m_en   = 1'b0;
  logic [AW-1:0] m_dest = '0;
  logic [DW-1:0] m_data = '0;

  // Reference: in-order list of pending load writes.
  task automatic model_edge();
    bit   rdy;
    bit   iss;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_en = 0; m_dest = '0; m_data = '0;
      return;
    end
    rdy = (mq.size() < DEPTH);
    iss = bus.alu_valid && (bus.alu_dest != 4'd15);
    if (iss) begin
      m_en = 1; m_dest = bus.alu_dest; m_data = bus.alu_data;
      foreach (mq[k])
        if (mq[k].dest == bus.alu_dest) mq[k].live = 0;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_en = e.live;
      if (e.live) begin
        m_dest = e.dest; m_data = e.data;
      end
    end else begin
      m_en = 0;
    end
    if (bus.ld_valid && rdy && bus.ld_dest != 4'd15) begin
      e.dest = bus.ld_dest; e.data = bus.ld_data; e.live = 1;
      mq.push_back(e);
    end
  endtask

  function automatic bit m_haz();
    foreach (mq[k])
      if (mq[k].live && (mq[k].dest == bus.q_src_1 ||
                         mq[k].dest == bus.q_src_2))
        return 1;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.alu_valid = 0; bus.alu_dest = '0; bus.alu_data = '0;
    bus.ld_valid  = 0; bus.ld_dest  = '0; bus.ld_data  = '0;
    bus.q_src_1   = '0; bus.q_src_2 = '0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    bus.alu_valid = 1; bus.alu_dest = 4'd2; bus.alu_data = 32'h1234;
    bus.ld_valid = 1; bus.ld_dest = 4'd3; bus.ld_data = 32'h5678;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (bus.WB_WB_EN !== 1'b0 || bus.fifo_count !== 3'd0 ||
          bus.ld_ready !== 1'b0) begin
        bad++;
        $display("FAIL reset[%0d] en=%b cnt=%0d rdy=%b want 0/0/0",
                 i, bus.WB_WB_EN, bus.fifo_count, bus.ld_ready);
      end
    end
    total++;
    if (bus.Dest_wb !== 4'd0 || bus.dest_wb !== 32'd0) begin
      bad++;
      $display("FAIL reset_out dest=%0d data=%h want 0/0",
               bus.Dest_wb, bus.dest_wb);
    end
    rst = 0;
    idle();
    #1;
    total++;
    if (bus.ld_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release rdy=%b want 1", bus.ld_ready);
    end
  endtask

  task automatic test_alu_only();
    idle();
    bus.alu_valid = 1; bus.alu_dest = 4'd3; bus.alu_data = 32'hDEADBEEF;
    tick();
    total++;
    if (bus.WB_WB_EN !== 1'b1 || bus.Dest_wb !== 4'd3 ||
        bus.dest_wb !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL alu_only en=%b dest=%0d data=%h want 1/3/deadbeef",
               bus.WB_WB_EN, bus.Dest_wb, bus.dest_wb);
    end
    idle();
    tick();
    total++;
    if (bus.WB_WB_EN !== 1'b0 || bus.Dest_wb !== 4'd3 ||
        bus.dest_wb !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL alu_hold en=%b dest=%0d data=%h want 0/3/deadbeef",
               bus.WB_WB_EN, bus.Dest_wb, bus.dest_wb);
    end
  endtask

  task automatic test_fill_drain();
    idle();
    bus.alu_valid = 1; bus.alu_dest = 4'd12;
    for (int i = 1; i <= 4; i++) begin
      bus.alu_data = 32'(i);
      bus.ld_valid = 1; bus.ld_dest = 4'(i); bus.ld_data = 32'(i * 16);
      tick();
    end
    bus.ld_dest = 4'd6; bus.ld_data = 32'h66;
    #1;
    total++;
    if (bus.fifo_count !== 3'd4 || bus.ld_ready !== 1'b0) begin
      bad++;
      $display("FAIL fill cnt=%0d rdy=%b want 4/0",
               bus.fifo_count, bus.ld_ready);
    end
    tick();
    total++;
    if (bus.fifo_count !== 3'd4) begin
      bad++;
      $display("FAIL fifth_push cnt=%0d want 4", bus.fifo_count);
    end
    idle();
    for (int i = 1; i <= 4; i++) begin
      tick();
      total++;
      if (bus.WB_WB_EN !== 1'b1 || bus.Dest_wb !== 4'(i) ||
          bus.dest_wb !== 32'(i * 16)) begin
        bad++;
        $display("FAIL drain[%0d] en=%b dest=%0d data=%h want 1/%0d/%h",
                 i, bus.WB_WB_EN, bus.Dest_wb, bus.dest_wb, i, i * 16);
      end
    end
    total++;
    if (bus.fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL drain_cnt cnt=%0d want 0", bus.fifo_count);
    end
  endtask

  task automatic test_kill();
    idle();
    bus.ld_valid = 1; bus.ld_dest = 4'd5; bus.ld_data = 32'h55;
    tick();
    idle();
    bus.q_src_1 = 4'd5;
    bus.alu_valid = 1; bus.alu_dest = 4'd5; bus.alu_data = 32'h99;
    #1;
    total++;
    if (bus.hazard !== 1'b1) begin
      bad++;
      $display("FAIL kill_haz_pre haz=%b want 1", bus.hazard);
    end
    tick();
    total++;
    if (bus.WB_WB_EN !== 1'b1 || bus.Dest_wb !== 4'd5 ||
        bus.dest_wb !== 32'h99 || bus.hazard !== 1'b0) begin
      bad++;
      $display("FAIL kill_alu en=%b dest=%0d data=%h haz=%b want 1/5/99/0",
               bus.WB_WB_EN, bus.Dest_wb, bus.dest_wb, bus.hazard);
    end
    bus.alu_valid = 0;
    tick();
    total++;
    if (bus.WB_WB_EN !== 1'b0 || bus.fifo_count !== 3'd0) begin
      bad++;
      $display("FAIL kill_pop en=%b cnt=%0d want 0/0",
               bus.WB_WB_EN, bus.fifo_count);
    end
  endtask

  task automatic test_hazard_pushpop();
    idle();
    bus.ld_valid = 1; bus.ld_dest = 4'd7; bus.ld_data = 32'h77;
    tick();
    bus.ld_dest = 4'd8; bus.ld_data = 32'h88;
    bus.q_src_2 = 4'd7;
    #1;
    total++;
    if (bus.hazard !== 1'b1) begin
      bad++;
      $display("FAIL haz7 haz=%b want 1", bus.hazard);
    end
    tick();
    total++;
    if (bus.fifo_count !== 3'd1 || bus.WB_WB_EN !== 1'b1 ||
        bus.Dest_wb !== 4'd7 || bus.hazard !== 1'b0) begin
      bad++;
      $display("FAIL pushpop cnt=%0d en=%b dest=%0d haz=%b want 1/1/7/0",
               bus.fifo_count, bus.WB_WB_EN, bus.Dest_wb, bus.hazard);
    end
    bus.ld_valid = 0;
    bus.q_src_1 = 4'd8;
    #1;
    total++;
    if (bus.hazard !== 1'b1) begin
      bad++;
      $display("FAIL haz8 haz=%b want 1", bus.hazard);
    end
    tick();
    total++;
    if (bus.WB_WB_EN !== 1'b1 || bus.Dest_wb !== 4'd8 ||
        bus.dest_wb !== 32'h88) begin
      bad++;
      $display("FAIL drain8 en=%b dest=%0d data=%h want 1/8/88",
               bus.WB_WB_EN, bus.Dest_wb, bus.dest_wb);
    end
  endtask

  task automatic test_dest15_and_reset();
    idle();
    bus.alu_valid = 1; bus.alu_dest = 4'd15; bus.alu_data = 32'hF0F0;
    bus.ld_valid = 1; bus.ld_dest = 4'd15; bus.ld_data = 32'hF1F1;
    tick();
    total++;
    if (bus.WB_WB_EN !== 1'b0 || bus.fifo_count !== 3'd0 ||
        bus.ld_ready !== 1'b1) begin
      bad++;
      $display("FAIL dest15 en=%b cnt=%0d rdy=%b want 0/0/1",
               bus.WB_WB_EN, bus.fifo_count, bus.ld_ready);
    end
    bus.alu_dest = 4'd12;
    for (int i = 1; i <= 3; i++) begin
      bus.ld_dest = 4'(i); bus.ld_data = 32'(i + 100);
      tick();
    end
    idle();
    tick();
    rst = 1;
    tick();
    rst = 0;
    total++;
    if (bus.fifo_count !== 3'd0 || bus.Dest_wb !== 4'd0) begin
      bad++;
      $display("FAIL mid_rst cnt=%0d dest=%0d want 0/0",
               bus.fifo_count, bus.Dest_wb);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (bus.WB_WB_EN !== 1'b0) begin
        bad++;
        $display("FAIL post_rst[%0d] en=%b want 0", i, bus.WB_WB_EN);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      bus.alu_valid = ($urandom_range(0, 9) < 4);
      bus.alu_dest  = 4'($urandom_range(0, 15));
      bus.alu_data  = $urandom;
      bus.ld_valid  = ($urandom_range(0, 9) < 6);
      bus.ld_dest   = 4'($urandom_range(0, 15));
      bus.ld_data   = $urandom;
      bus.q_src_1   = 4'($urandom_range(0, 15));
      bus.q_src_2   = 4'($urandom_range(0, 15));
      #1;
      total++;
      if (bus.ld_ready !== (!rst && mq.size() < DEPTH) ||
          bus.hazard !== m_haz()) begin
        bad++;
        $display("FAIL rnd_comb[%0d] rdy=%b haz=%b want %b/%b", c,
                 bus.ld_ready, bus.hazard,
                 (!rst && mq.size() < DEPTH), m_haz());
      end
      tick();
      total++;
      if (bus.WB_WB_EN !== m_en || bus.Dest_wb !== m_dest ||
          bus.dest_wb !== m_data ||
          bus.fifo_count !== 3'(mq.size())) begin
        bad++;
        $display("FAIL rnd_out[%0d] en=%b d=%0d v=%h n=%0d want %b/%0d/%h/%0d",
                 c, bus.WB_WB_EN, bus.Dest_wb, bus.dest_wb,
                 bus.fifo_count, m_en, m_dest, m_data, mq.size());
      end
    end
    rst = 0;
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_only();
    test_fill_drain();
    test_kill();
    test_hazard_pushpop();
    test_dest15_and_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
